pll_multi_cfg_seq: RTL and testbench

- Parametrised successor to the single-PLL control-field bundle.
- Owns the run-time frequency fields (ratio, fraction, zdiv0/zdiv1, ssc_en, pllen) for NumPll PLL instances.
- Applies a new frequency request to one selected PLL through a safe, fixed sequence: disable, load, settle, enable, wait for lock, restore SSC.
- Sits between the SoC register block (request side) and the PLL hard macros (field outputs plus lock inputs), and reports completion and lock-timeout errors per PLL.

---
 rtl/pll_multi_cfg_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_pll_multi_cfg_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_multi_cfg_seq.sv
// Multi-PLL frequency sequencer: owns the per-PLL control fields and walks one selected
// PLL through disable, load, settle, enable, lock wait and SSC restore.
module pll_multi_cfg_seq #(
    parameter int NumPll       = 2,
    parameter int IdxW         = (NumPll > 1) ? $clog2(NumPll) : 1,
    parameter int RatioW       = 10,
    parameter int FracW        = 24,
    parameter int SettleCycles = 16,
    parameter int LockStable   = 4,
    parameter int LockTimeout  = 4096,
    parameter int RatioRst     = 40
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [IdxW-1:0]               req_idx_i,
    input  logic [RatioW-1:0]             req_ratio_i,
    input  logic [FracW-1:0]              req_fraction_i,
    input  logic [RatioW:0]               req_zdiv0_i,
    input  logic [RatioW:0]               req_zdiv1_i,
    input  logic                          req_ssc_en_i,
    input  logic [NumPll-1:0]             pll_lock_i,
    output logic [NumPll-1:0]             pllen_o,
    output logic [NumPll-1:0]             ssc_en_o,
    output logic [NumPll*RatioW-1:0]      ratio_o,
    output logic [NumPll*FracW-1:0]       fraction_o,
    output logic [NumPll*(RatioW+1)-1:0]  zdiv0_o,
    output logic [NumPll*(RatioW+1)-1:0]  zdiv1_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          done_err_o,
    output logic [NumPll-1:0]             err_o
);

    localparam int ZW     = RatioW + 1;
    localparam int CntMax = (SettleCycles > LockTimeout) ? SettleCycles : LockTimeout;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int StbW   = $clog2(LockStable + 1);

    localparam logic [RatioW-1:0] RatioRstVal = RatioW'(RatioRst);
    localparam logic [ZW-1:0]     ZdivRstVal  = {1'b0, RatioW'(1)};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BADIDX,
        ST_DISABLE,
        ST_LOAD,
        ST_SETTLE,
        ST_ENABLE,
        ST_WAIT_LOCK,
        ST_SSC_ON,
        ST_FAIL
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [StbW-1:0]     stb_q, stb_d, stb_inc;

    logic [IdxW-1:0]     rq_idx_q, rq_idx_d;
    logic [RatioW-1:0]   rq_ratio_q, rq_ratio_d;
    logic [FracW-1:0]    rq_frac_q, rq_frac_d;
    logic [ZW-1:0]       rq_z0_q, rq_z0_d;
    logic [ZW-1:0]       rq_z1_q, rq_z1_d;
    logic                rq_ssc_q, rq_ssc_d;

    logic [NumPll-1:0]   pllen_q, pllen_d;
    logic [NumPll-1:0]   ssc_q, ssc_d;
    logic [NumPll-1:0]   err_q, err_d;
    logic [RatioW-1:0]   ratio_q [NumPll];
    logic [RatioW-1:0]   ratio_d [NumPll];
    logic [FracW-1:0]    frac_q  [NumPll];
    logic [FracW-1:0]    frac_d  [NumPll];
    logic [ZW-1:0]       z0_q    [NumPll];
    logic [ZW-1:0]       z0_d    [NumPll];
    logic [ZW-1:0]       z1_q    [NumPll];
    logic [ZW-1:0]       z1_d    [NumPll];

    logic [NumPll-1:0]   sync1_q, sync2_q;
    logic [NumPll-1:0]   lane_hit;
    logic                lock_sel;

    // NOTE: raw lock is asynchronous to clk_i; only the second flop may feed logic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pll_lock_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        lane_hit = '0;
        for (int k = 0; k < NumPll; k++) lane_hit[k] = (int'(rq_idx_q) == k);
    end

    assign lock_sel = |(sync2_q & lane_hit);
    assign cnt_inc  = (cnt_q == CntW'(CntMax))     ? cnt_q : cnt_q + CntW'(1);
    assign stb_inc  = (stb_q == StbW'(LockStable)) ? stb_q : stb_q + StbW'(1);

    // NOTE: every field is assigned its held value first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stb_d      = stb_q;
        rq_idx_d   = rq_idx_q;
        rq_ratio_d = rq_ratio_q;
        rq_frac_d  = rq_frac_q;
        rq_z0_d    = rq_z0_q;
        rq_z1_d    = rq_z1_q;
        rq_ssc_d   = rq_ssc_q;
        pllen_d    = pllen_q;
        ssc_d      = ssc_q;
        err_d      = err_q;
        ratio_d    = ratio_q;
        frac_d     = frac_q;
        z0_d       = z0_q;
        z1_d       = z1_q;
        done_o     = 1'b0;
        done_err_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    rq_idx_d   = req_idx_i;
                    rq_ratio_d = req_ratio_i;
                    rq_frac_d  = req_fraction_i;
                    rq_z0_d    = req_zdiv0_i;
                    rq_z1_d    = req_zdiv1_i;
                    rq_ssc_d   = req_ssc_en_i;
                    cnt_d      = '0;
                    state_d    = (int'(req_idx_i) < NumPll) ? ST_DISABLE : ST_BADIDX;
                end
            end
            ST_BADIDX: begin
                done_o     = 1'b1;
                done_err_o = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_DISABLE: begin
                pllen_d = pllen_q & ~lane_hit;
                ssc_d   = ssc_q & ~lane_hit;
                cnt_d   = cnt_inc;
                if (cnt_inc == CntW'(SettleCycles)) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                for (int k = 0; k < NumPll; k++) begin
                    if (lane_hit[k]) begin
                        ratio_d[k] = rq_ratio_q;
                        frac_d[k]  = rq_frac_q;
                        z0_d[k]    = rq_z0_q;
                        z1_d[k]    = rq_z1_q;
                    end
                end
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CntW'(SettleCycles)) begin
                    cnt_d   = '0;
                    state_d = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                pllen_d = pllen_q | lane_hit;
                cnt_d   = '0;
                stb_d   = '0;
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                stb_d = lock_sel ? stb_inc : '0;
                cnt_d = cnt_inc;
                // Reaching stable lock wins over a timeout landing on the same cycle.
                if (lock_sel && stb_inc == StbW'(LockStable)) begin
                    state_d = ST_SSC_ON;
                end else if (cnt_inc == CntW'(LockTimeout)) begin
                    state_d = ST_FAIL;
                end
            end
            ST_SSC_ON: begin
                ssc_d   = rq_ssc_q ? (ssc_q | lane_hit) : (ssc_q & ~lane_hit);
                err_d   = err_q & ~lane_hit;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                pllen_d    = pllen_q & ~lane_hit;
                err_d      = err_q | lane_hit;
                done_o     = 1'b1;
                done_err_o = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the lane arrays drive PLL pins directly, so they are reset like any other register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            stb_q      <= '0;
            rq_idx_q   <= '0;
            rq_ratio_q <= '0;
            rq_frac_q  <= '0;
            rq_z0_q    <= '0;
            rq_z1_q    <= '0;
            rq_ssc_q   <= 1'b0;
            pllen_q    <= '0;
            ssc_q      <= '0;
            err_q      <= '0;
            for (int k = 0; k < NumPll; k++) begin
                ratio_q[k] <= RatioRstVal;
                frac_q[k]  <= '0;
                z0_q[k]    <= ZdivRstVal;
                z1_q[k]    <= ZdivRstVal;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stb_q      <= stb_d;
            rq_idx_q   <= rq_idx_d;
            rq_ratio_q <= rq_ratio_d;
            rq_frac_q  <= rq_frac_d;
            rq_z0_q    <= rq_z0_d;
            rq_z1_q    <= rq_z1_d;
            rq_ssc_q   <= rq_ssc_d;
            pllen_q    <= pllen_d;
            ssc_q      <= ssc_d;
            err_q      <= err_d;
            ratio_q    <= ratio_d;
            frac_q     <= frac_d;
            z0_q       <= z0_d;
            z1_q       <= z1_d;
        end
    end

    for (genvar g = 0; g < NumPll; g++) begin : g_lane
        assign ratio_o[g*RatioW +: RatioW]  = ratio_q[g];
        assign fraction_o[g*FracW +: FracW] = frac_q[g];
        assign zdiv0_o[g*ZW +: ZW]          = z0_q[g];
        assign zdiv1_o[g*ZW +: ZW]          = z1_q[g];
    end

    assign pllen_o     = pllen_q;
    assign ssc_en_o    = ssc_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign req_ready_o = (state_q == ST_IDLE);

endmodule

// File: tb/tb_pll_multi_cfg_seq.sv
// Self-checking bench for pll_multi_cfg_seq: directed table, hand sequences and random
// transactions compared cycle by cycle against a transaction-level timing model.
module tb_pll_multi_cfg_seq;

    localparam int NP   = 3;
    localparam int IW   = 2;
    localparam int RW   = 10;
    localparam int FW   = 24;
    localparam int ZW   = RW + 1;
    localparam int S    = 16;
    localparam int LS   = 4;
    localparam int TMO  = 64;
    localparam int RRST = 40;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [IW-1:0]       req_idx_i;
    logic [RW-1:0]       req_ratio_i;
    logic [FW-1:0]       req_fraction_i;
    logic [ZW-1:0]       req_zdiv0_i;
    logic [ZW-1:0]       req_zdiv1_i;
    logic                req_ssc_en_i;
    logic [NP-1:0]       pll_lock_i;
    logic [NP-1:0]       pllen_o;
    logic [NP-1:0]       ssc_en_o;
    logic [NP*RW-1:0]    ratio_o;
    logic [NP*FW-1:0]    fraction_o;
    logic [NP*ZW-1:0]    zdiv0_o;
    logic [NP*ZW-1:0]    zdiv1_o;
    logic                busy_o;
    logic                done_o;
    logic                done_err_o;
    logic [NP-1:0]       err_o;

    always #5 clk_i = ~clk_i;

    pll_multi_cfg_seq #(
        .NumPll(NP), .RatioW(RW), .FracW(FW), .SettleCycles(S),
        .LockStable(LS), .LockTimeout(TMO), .RatioRst(RRST)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_idx_i(req_idx_i), .req_ratio_i(req_ratio_i),
        .req_fraction_i(req_fraction_i), .req_zdiv0_i(req_zdiv0_i),
        .req_zdiv1_i(req_zdiv1_i), .req_ssc_en_i(req_ssc_en_i),
        .pll_lock_i(pll_lock_i), .pllen_o(pllen_o), .ssc_en_o(ssc_en_o),
        .ratio_o(ratio_o), .fraction_o(fraction_o), .zdiv0_o(zdiv0_o),
        .zdiv1_o(zdiv1_o), .busy_o(busy_o), .done_o(done_o),
        .done_err_o(done_err_o), .err_o(err_o)
    );

    // Lock seen by the sequencer in WAIT_LOCK cycle j (j>=1) is 0 before start, then pat, then tail.
    typedef struct {
        logic [IW-1:0] idx;
        logic [RW-1:0] ratio;
        logic [FW-1:0] frac;
        logic [ZW-1:0] z0;
        logic [ZW-1:0] z1;
        logic          ssc;
        int            start;
        logic [15:0]   pat;
        logic          tail;
        bit            has_exp;
        bit            exp_err;
        int            exp_wait;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    logic [NP-1:0] m_pllen, m_ssc, m_err;
    logic [RW-1:0] m_ratio [NP];
    logic [FW-1:0] m_frac  [NP];
    logic [ZW-1:0] m_z0    [NP];
    logic [ZW-1:0] m_z1    [NP];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pllen = '0;
        m_ssc   = '0;
        m_err   = '0;
        for (int k = 0; k < NP; k++) begin
            m_ratio[k] = RW'(RRST);
            m_frac[k]  = '0;
            m_z0[k]    = {1'b0, RW'(1)};
            m_z1[k]    = {1'b0, RW'(1)};
        end
    endtask

    task automatic check_outputs(input string tag, input bit busy, input bit done, input bit derr);
        logic [NP*RW-1:0] pr;
        logic [NP*FW-1:0] pf;
        logic [NP*ZW-1:0] p0, p1;
        for (int k = 0; k < NP; k++) begin
            pr[k*RW +: RW] = m_ratio[k];
            pf[k*FW +: FW] = m_frac[k];
            p0[k*ZW +: ZW] = m_z0[k];
            p1[k*ZW +: ZW] = m_z1[k];
        end
        check($sformatf("%s busy", tag),     128'(busy_o),      128'(busy));
        check($sformatf("%s ready", tag),    128'(req_ready_o), 128'(!busy));
        check($sformatf("%s done", tag),     128'(done_o),      128'(done));
        check($sformatf("%s done_err", tag), 128'(done_err_o),  128'(derr));
        check($sformatf("%s pllen", tag),    128'(pllen_o),     128'(m_pllen));
        check($sformatf("%s ssc_en", tag),   128'(ssc_en_o),    128'(m_ssc));
        check($sformatf("%s err", tag),      128'(err_o),       128'(m_err));
        check($sformatf("%s ratio", tag),    128'(ratio_o),     128'(pr));
        check($sformatf("%s fraction", tag), 128'(fraction_o),  128'(pf));
        check($sformatf("%s zdiv0", tag),    128'(zdiv0_o),     128'(p0));
        check($sformatf("%s zdiv1", tag),    128'(zdiv1_o),     128'(p1));
    endtask

    function automatic logic lock_at(input vec_t v, input int j);
        if (j < v.start) return 1'b0;
        if (j - v.start < 16) return v.pat[j - v.start];
        return v.tail;
    endfunction

    function automatic vec_t mk(input int idx, input int ratio, input int frac, input int z0,
                                input int z1, input bit ssc, input int start, input int pat,
                                input bit tail, input bit exp_err, input int exp_wait);
        vec_t v;
        v.idx = IW'(idx);     v.ratio = RW'(ratio); v.frac = FW'(frac);
        v.z0 = ZW'(z0);       v.z1 = ZW'(z1);       v.ssc = ssc;
        v.start = start;      v.pat = 16'(pat);     v.tail = tail;
        v.has_exp = 1'b1;     v.exp_err = exp_err;  v.exp_wait = exp_wait;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v.idx = IW'($urandom_range(0, NP - 1));
        v.ratio = RW'($urandom);  v.frac = FW'($urandom);
        v.z0 = ZW'($urandom);     v.z1 = ZW'($urandom);
        v.ssc = 1'($urandom);     v.start = $urandom_range(1, 70);
        v.pat = 16'($urandom);    v.tail = 1'($urandom);
        v.has_exp = 1'b0;         v.exp_err = 1'b0;  v.exp_wait = 0;
        return v;
    endfunction

    // Start at/after a negedge of an idle cycle; return at the negedge of the first IDLE cycle.
    task automatic run_txn(input vec_t v, input bit hold_next, input vec_t nv, input int abort_t);
        bit   ok;
        int   jw, run, last, t_done, wait_c, i;
        logic d_err;
        string tag;
        // Outcome from the lock rules alone.
        ok = 1'b0; jw = TMO; run = 0;
        for (int j = 1; j <= TMO; j++) begin
            run = lock_at(v, j) ? run + 1 : 0;
            if (run == LS) begin ok = 1'b1; jw = j; break; end
        end
        i = int'(v.idx);
        txn_no++;
        wait_c = 0;
        while (!req_ready_o && wait_c < 200) begin
            @(negedge clk_i);
            wait_c++;
        end
        check($sformatf("txn%0d ready before request", txn_no), 128'(req_ready_o), 128'(1));
        req_valid_i = 1'b1;  req_idx_i = v.idx;  req_ratio_i = v.ratio;
        req_fraction_i = v.frac;  req_zdiv0_i = v.z0;  req_zdiv1_i = v.z1;
        req_ssc_en_i = v.ssc;
        @(posedge clk_i);
        #1;
        if (hold_next) begin
            req_idx_i = nv.idx;  req_ratio_i = nv.ratio;  req_fraction_i = nv.frac;
            req_zdiv0_i = nv.z0; req_zdiv1_i = nv.z1;     req_ssc_en_i = nv.ssc;
        end else begin
            req_valid_i = 1'b0;
        end
        last = 2*S + 3 + jw;
        t_done = -1;
        d_err = 1'b0;
        for (int t = 0; t <= last; t++) begin
            for (int k = 0; k < NP; k++)
                pll_lock_i[k] = (k == i) ? lock_at(v, t - 2*S + 1) : 1'($urandom);
            @(negedge clk_i);
            if (t == 1) begin m_pllen[i] = 1'b0; m_ssc[i] = 1'b0; end
            if (t == S + 1) begin
                m_ratio[i] = v.ratio; m_frac[i] = v.frac; m_z0[i] = v.z0; m_z1[i] = v.z1;
            end
            if (t == 2*S + 2) m_pllen[i] = 1'b1;
            if (t == last) begin
                if (ok) begin m_ssc[i] = v.ssc; m_err[i] = 1'b0; end
                else    begin m_pllen[i] = 1'b0; m_err[i] = 1'b1; end
            end
            if (done_o === 1'b1 && t_done < 0) begin t_done = t; d_err = done_err_o; end
            tag = $sformatf("txn%0d t%0d", txn_no, t);
            check_outputs(tag, t < last, t == last - 1, (t == last - 1) && !ok);
            if (t == abort_t) begin
                #2 rst_ni = 1'b0;
                #1;
                model_reset();
                check_outputs($sformatf("txn%0d async reset", txn_no), 1'b0, 1'b0, 1'b0);
                @(negedge clk_i);
                rst_ni = 1'b1;
                return;
            end
            if (t < last) begin
                @(posedge clk_i);
                #1;
            end
        end
        if (v.has_exp) begin
            check($sformatf("txn%0d wait cycles", txn_no), 128'(t_done - (2*S + 2)), 128'(v.exp_wait));
            check($sformatf("txn%0d done_err", txn_no), 128'(d_err), 128'(v.exp_err));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        vec_t none, va, vb, vr;
        bit   h;

        // idx ratio frac z0 z1 ssc start pat tail exp_err exp_wait
        tbl[0] = mk(1, 100,  'h400000, 'h003, 'h405, 1,   23, 'hFFFF, 1, 0, 26); // lock 20 cycles after pllen rise
        tbl[1] = mk(0, 200,  'h123456, 'h002, 'h002, 1, 1000, 'h0000, 0, 1, 64); // never locks
        tbl[2] = mk(0, 201,  'h000001, 'h404, 'h006, 0,    1, 'hFFFF, 1, 0,  4); // clears err[0]
        tbl[3] = mk(1, 333,  'hABCDEF, 'h111, 'h222, 1,    5, 'hFFF7, 1, 0, 12); // 1,1,1,0,1,1,1,1
        tbl[4] = mk(2, 512,  'h0F0F0F, 'h7FF, 'h000, 1,   61, 'hFFFF, 1, 0, 64); // stable hits 4 at timeout
        tbl[5] = mk(2, 513,  'h00FF00, 'h001, 'h3FF, 1,   62, 'hFFFF, 1, 1, 64); // one cycle too late
        tbl[6] = mk(2, 1023, 'hFFFFFF, 'h400, 'h400, 0,   10, 'hFFFF, 1, 0, 13);
        tbl[7] = mk(1, 7,    'h000000, 'h00A, 'h00B, 1,    1, 'h5555, 0, 1, 64); // never 4 in a row
        none = mk(0, 0, 0, 0, 0, 0, 1000, 0, 0, 0, 0);

        rst_ni = 1'b0;  req_valid_i = 1'b0;  req_idx_i = '0;  req_ratio_i = '0;
        req_fraction_i = '0;  req_zdiv0_i = '0;  req_zdiv1_i = '0;  req_ssc_en_i = 1'b0;
        pll_lock_i = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check_outputs("reset", 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_outputs("after reset release", 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 8; n++) run_txn(tbl[n], 1'b0, none, -1);

        // Reset asserted in WAIT_LOCK, ten cycles after pllen rises.
        va = mk(0, 300, 'h55AA55, 'h010, 'h020, 1, 1000, 'h0000, 0, 1, 64);
        va.has_exp = 1'b0;
        run_txn(va, 1'b0, none, 2*S + 1 + 10);

        // Second request held valid during the first: accepted the cycle after done.
        va = mk(0, 55, 'h000111, 'h005, 'h006, 1, 3, 'hFFFF, 1, 0, 6);
        vb = mk(2, 77, 'h000222, 'h007, 'h008, 0, 1, 'hFFFF, 1, 0, 4);
        run_txn(va, 1'b1, vb, -1);
        run_txn(vb, 1'b0, none, -1);

        // Out-of-range index.
        req_valid_i = 1'b1;  req_idx_i = 2'd3;  req_ratio_i = 10'd999;
        req_fraction_i = 24'hFFFFFF;  req_zdiv0_i = '1;  req_zdiv1_i = '1;  req_ssc_en_i = 1'b1;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        check_outputs("badidx cycle", 1'b1, 1'b1, 1'b1);
        @(negedge clk_i);
        check_outputs("badidx after", 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 5; n++) begin
            vr = rnd_vec();
            vb = rnd_vec();
            h  = 1'($urandom);
            run_txn(vr, h, vb, -1);
            run_txn(vb, 1'b0, none, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
